// File: rtl/ps_pot_pkg.sv
// Shared types and constants for the power-supply pot trim loop.
// Used by ps_pot_trim and ps_trim_avg.
package ps_pot_pkg;

  localparam int PS_DW = 10;

  localparam logic [5:0] CMD_WRITE_RDAC = 6'b000001;

  localparam logic [PS_DW-1:0] RAIL_LO = 10'd0;
  localparam logic [PS_DW-1:0] RAIL_HI = 10'd1023;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    HI_GAP,
    LO,
    SETTLE,
    MEASURE,
    DECIDE
  } ps_trim_state_t;

endpackage

// File: rtl/ps_trim_avg.sv
// Four-sample ADC accumulator; avg is the truncated mean.
// Only built when PS_POT_TRIM_AVG_EN is defined.
module ps_trim_avg
  import ps_pot_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             valid,
  input  logic [PS_DW-1:0] din,
  output logic             done,
  output logic [PS_DW-1:0] avg
);

  logic [11:0] sum;
  logic [2:0]  n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
      n   <= '0;
    end else if (clr) begin
      sum <= '0;
      n   <= '0;
    end else if (valid && !n[2]) begin
      sum <= sum + {2'b00, din};
      n   <= n + 3'd1;
    end
  end

  assign done = n[2];
  assign avg  = sum[11:2];

endmodule

// File: rtl/ps_pot_trim.sv
// Closed-loop digital pot trim: steps the wiper until ADC is in band.
// Define PS_POT_TRIM_AVG_EN to average 4 samples per decision.
module ps_pot_trim
  import ps_pot_pkg::*;
#(
  parameter int DEADBAND   = 4,
  parameter int STEP       = 1,
  parameter int SETTLE_CYC = 1000,
  parameter int LOCK_CNT   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [PS_DW-1:0] d_init,
  input  logic [PS_DW-1:0] ps_ref,
  input  logic [PS_DW-1:0] ps_dig,
  input  logic             ps_dig_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_byte,
  output logic             tx_dv,
  output logic [PS_DW-1:0] d_code,
  output logic             busy,
  output logic             locked,
  output logic             sat
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [LW-1:0] LK      = LW'(LOCK_CNT);
  localparam logic [CW-1:0] SC_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [10:0]   DB      = 11'(DEADBAND);
  localparam logic [10:0]   ST      = 11'(STEP);
  localparam logic [10:0]   TOP     = {1'b0, RAIL_HI};

  ps_trim_state_t state, state_n;

  logic [PS_DW-1:0] d_code_n, sample, sample_n;
  logic [7:0]       tx_byte_n;
  logic             tx_dv_n, locked_n, sat_n;
  logic [LW-1:0]    lock_q, lock_n;
  logic [CW-1:0]    cnt, cnt_n;

  logic             meas_ok;
  logic [PS_DW-1:0] meas_val;

`ifdef PS_POT_TRIM_AVG_EN
  logic             avg_clr, avg_valid, avg_done;
  logic [PS_DW-1:0] avg;

  // Accumulator restarts on every entry to MEASURE.
  assign avg_clr   = (state_n == MEASURE) && (state != MEASURE);
  assign avg_valid = ps_dig_valid & enable & (state == MEASURE);

  ps_trim_avg u_avg (
    .clk   (clk),
    .reset (reset),
    .clr   (avg_clr),
    .valid (avg_valid),
    .din   (ps_dig),
    .done  (avg_done),
    .avg   (avg)
  );

  assign meas_ok  = avg_done;
  assign meas_val = avg;
`else
  assign meas_ok  = ps_dig_valid;
  assign meas_val = ps_dig;
`endif

  logic [10:0] ref11, win_lo, win_hi, smp11, code11;
  logic [10:0] up, dn, new_code;
  logic        in_band;

  always_comb begin
    ref11  = {1'b0, ps_ref};
    smp11  = {1'b0, sample};
    code11 = {1'b0, d_code};
    win_lo = (ref11 < DB) ? 11'd0 : ref11 - DB;
    win_hi = (ref11 + DB > TOP) ? TOP : ref11 + DB;
    up     = (code11 + ST > TOP) ? TOP : code11 + ST;
    dn     = (code11 < ST) ? 11'd0 : code11 - ST;
    in_band  = 1'b0;
    new_code = code11;
    unique case (1'b1)
      (smp11 < win_lo): new_code = up;
      (smp11 > win_hi): new_code = dn;
      default:          in_band  = 1'b1;
    endcase
  end

  always_comb begin
    state_n   = state;
    d_code_n  = d_code;
    tx_byte_n = tx_byte;
    tx_dv_n   = 1'b0;
    locked_n  = locked;
    sat_n     = sat;
    lock_n    = lock_q;
    cnt_n     = cnt;
    sample_n  = sample;
    unique case (state)
      IDLE: begin
        if (enable) begin
          d_code_n = d_init;
          state_n  = HI;
        end
      end
      HI: begin
        if (tx_ready) begin
          tx_byte_n = {CMD_WRITE_RDAC, d_code[9:8]};
          tx_dv_n   = 1'b1;
          state_n   = HI_GAP;
        end
      end
      HI_GAP: state_n = LO;
      LO: begin
        if (tx_ready) begin
          tx_byte_n = d_code[7:0];
          tx_dv_n   = 1'b1;
          cnt_n     = '0;
          state_n   = enable ? SETTLE : IDLE;
        end
      end
      SETTLE: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (cnt == SC_LAST) begin
          cnt_n   = '0;
          state_n = MEASURE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (meas_ok) begin
          sample_n = meas_val;
          state_n  = DECIDE;
        end
      end
      DECIDE: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (in_band) begin
          if (lock_q != LK) lock_n = lock_q + 1'b1;
          locked_n = (lock_n == LK);
          state_n  = MEASURE;
        end else begin
          lock_n   = '0;
          locked_n = 1'b0;
          if (new_code != code11) begin
            d_code_n = new_code[PS_DW-1:0];
            sat_n    = 1'b0;
            state_n  = HI;
          end else begin
            sat_n   = 1'b1;
            state_n = MEASURE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Status never survives into IDLE.
    if (state_n == IDLE) begin
      locked_n = 1'b0;
      sat_n    = 1'b0;
      lock_n   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx_byte <= '0;
      tx_dv   <= 1'b0;
      d_code  <= '0;
      busy    <= 1'b0;
      locked  <= 1'b0;
      sat     <= 1'b0;
      lock_q  <= '0;
      cnt     <= '0;
      sample  <= '0;
    end else begin
      state   <= state_n;
      tx_byte <= tx_byte_n;
      tx_dv   <= tx_dv_n;
      d_code  <= d_code_n;
      busy    <= (state_n != IDLE);
      locked  <= locked_n;
      sat     <= sat_n;
      lock_q  <= lock_n;
      cnt     <= cnt_n;
      sample  <= sample_n;
    end
  end

endmodule
